// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the MEM stage (priority) and a DMA/loader port with a CPU starvation limit.
// Define ARB_STATS_EN to add saturating stall / DMA-beat counters (stat_stall, stat_dma_beats).
module dmem_arbiter #(
  parameter int AW       = 5,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  input  logic          dma_last,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]   stat_stall,
  output logic [15:0]   stat_dma_beats
`endif
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, CPU, DMA} owner_t;

  owner_t        owner;
  logic [WW-1:0] wait_cnt;
  logic          force_cpu;
  logic          cpu_serve;
  logic          dma_serve;

  // Reset gates every grant so the memory sees no write while Resetn is low.
  always_comb begin
    force_cpu = (owner == DMA) && cpu_req && (wait_cnt == WW'(MAX_WAIT));
    cpu_serve = 1'b0;
    dma_serve = 1'b0;
    if (Resetn) begin
      if (owner == DMA) begin
        if (force_cpu)    cpu_serve = 1'b1;
        else if (dma_req) dma_serve = 1'b1;
        else              cpu_serve = cpu_req;
      end else begin
        if (cpu_req)      cpu_serve = 1'b1;
        else if (dma_req) dma_serve = 1'b1;
      end
    end
  end

  assign cpu_stall = Resetn & cpu_req & ~cpu_serve;
  assign dma_gnt   = dma_serve;
  assign mem_we    = dma_serve ? dma_we    : (cpu_serve & cpu_we);
  assign mem_addr  = dma_serve ? dma_addr  : cpu_addr;
  assign mem_wdata = dma_serve ? dma_wdata : cpu_wdata;
  assign cpu_rdata = mem_rdata;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      owner      <= IDLE;
      wait_cnt   <= '0;
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      dma_rvalid <= dma_serve & ~dma_we;
      if (dma_serve && !dma_we) dma_rdata <= mem_rdata;

      case (owner)
        DMA: begin
          if (force_cpu) begin
            owner    <= IDLE;
            wait_cnt <= '0;
          end else if (dma_req) begin
            if (dma_last) begin
              owner    <= IDLE;
              wait_cnt <= '0;
            end else begin
              owner    <= DMA;
              wait_cnt <= cpu_req ? wait_cnt + WW'(1) : '0;
            end
          end else begin
            owner    <= cpu_req ? CPU : IDLE;
            wait_cnt <= '0;
          end
        end
        default: begin
          wait_cnt <= '0;
          if (cpu_req)      owner <= CPU;
          else if (dma_req) owner <= dma_last ? IDLE : DMA;
          else              owner <= IDLE;
        end
      endcase
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      stat_stall     <= '0;
      stat_dma_beats <= '0;
    end else begin
      if (cpu_stall && stat_stall != 16'hFFFF)   stat_stall     <= stat_stall + 16'd1;
      if (dma_gnt && stat_dma_beats != 16'hFFFF) stat_dma_beats <= stat_dma_beats + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed cycles push expectations, a negedge monitor pops and compares.
// Connects the stats ports when ARB_STATS_EN is defined.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0, dma_last = 1'b0;
  logic [4:0]  cpu_addr = '0, dma_addr = '0;
  logic [31:0] cpu_wdata = '0, dma_wdata = '0;
  logic [31:0] cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
  logic        cpu_stall, dma_gnt, dma_rvalid, mem_we;
  logic [4:0]  mem_addr;
`ifdef ARB_STATS_EN
  logic [15:0] stat_stall, stat_dma_beats;
`endif

  dmem_arbiter #(.AW(5), .DW(32), .MAX_WAIT(4)) dut (
    .Clock(clk), .Resetn(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_last(dma_last), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef ARB_STATS_EN
    , .stat_stall(stat_stall), .stat_dma_beats(stat_dma_beats)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural 32-word memory; word 5 preloaded with CAFE for the DMA read.
  logic [31:0] mem [32];
  logic        mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hA000_0000 + 32'(i);
      mem[5]   <= 32'h0000_CAFE;
      mem_init <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  typedef struct packed {
    logic        stall;
    logic        gnt;
    logic        we;
    logic [4:0]  addr;
    logic        chk_crd;
    logic [31:0] crd;
    logic [7:0]  tag;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rd_q[$];
  int          checks = 0;
  int          failures = 0;
  int          step_no = 0;
  exp_t        mon_e;

  function automatic void checkOutput(string name, int tag, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s step=%0d actual=%h required=%h", name, tag, act, req);
    end
  endfunction

  task automatic applyStimulus(input logic rst, input logic cr, input logic cw, input logic [4:0] ca,
                               input logic [31:0] cd, input logic dr, input logic dw, input logic [4:0] da,
                               input logic [31:0] dd, input logic dl,
                               input logic es, input logic eg, input logic ew, input logic [4:0] ea,
                               input logic chk, input logic [31:0] crd);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd; dma_last = dl;
    step_no++;
    e.stall = es; e.gnt = eg; e.we = ew; e.addr = ea; e.chk_crd = chk; e.crd = crd;
    e.tag = 8'(step_no);
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checkOutput("cpu_stall", int'(mon_e.tag), 32'(cpu_stall), 32'(mon_e.stall));
      checkOutput("dma_gnt",   int'(mon_e.tag), 32'(dma_gnt),   32'(mon_e.gnt));
      checkOutput("mem_we",    int'(mon_e.tag), 32'(mem_we),    32'(mon_e.we));
      checkOutput("mem_addr",  int'(mon_e.tag), 32'(mem_addr),  32'(mon_e.addr));
      if (mon_e.chk_crd) checkOutput("cpu_rdata", int'(mon_e.tag), cpu_rdata, mon_e.crd);
    end
    if (dma_rvalid) begin
      if (rd_q.size() == 0) checkOutput("dma_rvalid_unexpected", step_no, 32'd1, 32'd0);
      else                  checkOutput("dma_rdata", step_no, dma_rdata, rd_q.pop_front());
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    // reset held: requests present but nothing granted or written
    applyStimulus(0, 1,1,5'd3,32'h1234, 1,1,5'd9,32'h9,0,         0,0,0,5'd3, 0,32'h0);
    // reset release, CPU store served immediately
    applyStimulus(1, 1,1,5'd3,32'h1234, 0,0,5'd0,32'h0,0,         0,0,1,5'd3, 0,32'h0);
    applyStimulus(1, 0,0,5'd0,32'h0,    0,0,5'd0,32'h0,0,         0,0,0,5'd0, 0,32'h0);
    // simultaneous requests from IDLE: CPU wins, load sees the earlier store
    applyStimulus(1, 1,0,5'd3,32'h0,    1,1,5'd8,32'hB000_0008,0, 0,0,0,5'd3, 1,32'h1234);
    // four-beat write burst 8..11
    applyStimulus(1, 0,0,5'd0,32'h0,    1,1,5'd8,32'hB000_0008,0, 0,1,1,5'd8, 0,32'h0);
    applyStimulus(1, 0,0,5'd0,32'h0,    1,1,5'd9,32'hB000_0009,0, 0,1,1,5'd9, 0,32'h0);
    applyStimulus(1, 0,0,5'd0,32'h0,    1,1,5'd10,32'hB000_000A,0,0,1,1,5'd10,0,32'h0);
    applyStimulus(1, 0,0,5'd0,32'h0,    1,1,5'd11,32'hB000_000B,1,0,1,1,5'd11,0,32'h0);
    // owner back to IDLE: CPU beats a new DMA request
    applyStimulus(1, 1,0,5'd9,32'h0,    1,1,5'd16,32'hD000_0010,0,0,0,0,5'd9, 1,32'hB000_0009);
    // starvation burst: first beat uncontested, then four stalled beats
    applyStimulus(1, 0,0,5'd0,32'h0,    1,1,5'd16,32'hD000_0010,0,0,1,1,5'd16,0,32'h0);
    applyStimulus(1, 1,0,5'd8,32'h0,    1,1,5'd17,32'hD000_0011,0,1,1,1,5'd17,0,32'h0);
    applyStimulus(1, 1,0,5'd8,32'h0,    1,1,5'd18,32'hD000_0012,0,1,1,1,5'd18,0,32'h0);
    applyStimulus(1, 1,0,5'd8,32'h0,    1,1,5'd19,32'hD000_0013,0,1,1,1,5'd19,0,32'h0);
    applyStimulus(1, 1,0,5'd8,32'h0,    1,1,5'd20,32'hD000_0014,0,1,1,1,5'd20,0,32'h0);
    // fifth cycle: CPU forced in
    applyStimulus(1, 1,0,5'd8,32'h0,    1,1,5'd21,32'hD000_0015,0,0,0,0,5'd8, 1,32'hB000_0008);
`ifdef ARB_STATS_EN
    checkOutput("stat_stall", step_no, 32'(stat_stall), 32'd4);
    checkOutput("stat_dma_beats", step_no, 32'(stat_dma_beats), 32'd9);
`endif
    // CPU still requesting: pending beat keeps waiting
    applyStimulus(1, 1,0,5'd10,32'h0,   1,1,5'd21,32'hD000_0015,0,0,0,0,5'd10,1,32'hB000_000A);
    applyStimulus(1, 0,0,5'd0,32'h0,    1,1,5'd21,32'hD000_0015,0,0,1,1,5'd21,0,32'h0);
    // DMA read of word 5
    rd_q.push_back(32'h0000_CAFE);
    applyStimulus(1, 0,0,5'd0,32'h0,    1,0,5'd5,32'h0,0,         0,1,0,5'd5, 0,32'h0);
    applyStimulus(1, 0,0,5'd0,32'h0,    1,1,5'd22,32'hD000_0016,0,0,1,1,5'd22,0,32'h0);
    // reset mid-burst
    applyStimulus(0, 1,1,5'd4,32'h44,   1,1,5'd23,32'hD000_0017,0,0,0,0,5'd4, 0,32'h0);
`ifdef ARB_STATS_EN
    checkOutput("stat_stall_reset", step_no, 32'(stat_stall), 32'd0);
    checkOutput("stat_dma_beats_reset", step_no, 32'(stat_dma_beats), 32'd0);
`endif
    // burst aborted: CPU wins against re-issued beat
    applyStimulus(1, 1,0,5'd22,32'h0,   1,1,5'd23,32'hD000_0017,1,0,0,0,5'd22,1,32'hD000_0016);
    applyStimulus(1, 0,0,5'd0,32'h0,    1,1,5'd23,32'hD000_0017,1,0,1,1,5'd23,0,32'h0);
    applyStimulus(1, 1,0,5'd23,32'h0,   0,0,5'd0,32'h0,0,         0,0,0,5'd23,1,32'hD000_0017);
    applyStimulus(1, 0,0,5'd0,32'h0,    0,0,5'd0,32'h0,0,         0,0,0,5'd0, 0,32'h0);
    for (int i = 0; i < 10 && (exp_q.size() > 0 || rd_q.size() > 0); i++) @(negedge clk);
    @(negedge clk);
    checkOutput("exp_queue_drained", step_no, 32'(exp_q.size()), 32'd0);
    checkOutput("dma_read_queue_drained", step_no, 32'(rd_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
